// File: rtl/if_id_stage.sv
// if_id_stage: RV32I fetch-side PC, instruction-memory address and IF/ID register with stall/flush handling and stall watchdog
// ports: clk, rst_n (sync active-low); pc_write/if_id_write stall enables; br_taken/br_target redirect;
//        imem_rdata in, imem_addr out; id_pc/id_instr/id_valid to ID; stall_timeout sticky watchdog flag.
// IF_ID_PERF_EN adds perf_stall_cnt and perf_flush_cnt outputs.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        stall_timeout
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_t;
  localparam logic [7:0] MAX_C = 8'(MAX_STALL);
  state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_pc, r_id_pc, r_id_instr;
  logic r_id_valid;
  logic w_stall;
  assign w_stall = !pc_write && !br_taken;
  always_comb begin
    w_cnt_nxt = !w_stall ? 8'd0 : r_state == RUN ? 8'd1 : r_cnt == 8'hFF ? r_cnt : r_cnt + 8'd1;
    w_state_nxt = r_state == TIMEOUT ? TIMEOUT : !w_stall ? RUN : w_cnt_nxt >= MAX_C ? TIMEOUT : STALL;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_cnt      <= 8'd0;
      r_pc       <= RESET_PC;
      r_id_pc    <= 32'd0;
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= br_taken ? br_target : pc_write ? r_pc + 32'd4 : r_pc;
      if (br_taken) begin
        r_id_instr <= NOP_INSTR;
        r_id_valid <= 1'b0;
      end else if (if_id_write) begin
        r_id_instr <= imem_rdata;
        r_id_pc    <= r_pc;
        r_id_valid <= 1'b1;
      end
    end
  end
  assign imem_addr     = r_pc;
  assign id_pc         = r_id_pc;
  assign id_instr      = r_id_instr;
  assign id_valid      = r_id_valid;
  assign stall_timeout = r_state == TIMEOUT;
`ifdef IF_ID_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      r_perf_stall <= r_perf_stall + {31'd0, w_stall};
      r_perf_flush <= r_perf_flush + {31'd0, br_taken};
    end
  end
  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif
endmodule
